// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy spawn/motion blocks: arena geometry,
// coordinate type and the mover state encoding.
package enemy_pkg;

    localparam int CW       = 11;
    localparam int TARGET_X = 320;
    localparam int TARGET_Y = 340;

    typedef logic [CW-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        WAIT = 2'd2,
        STEP = 2'd3
    } state_t;

endpackage

// File: rtl/line_stepper.sv
// Combinational single Bresenham step toward (TX, TY). Error terms are
// signed CW+2 bits; the doubled error uses one extra bit so 2*err never wraps.
module line_stepper #(
    parameter int CW = enemy_pkg::CW,
    parameter int TX = enemy_pkg::TARGET_X,
    parameter int TY = enemy_pkg::TARGET_Y
) (
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    input  logic signed [CW+1:0] err,
    input  logic signed [CW+1:0] dx,
    input  logic signed [CW+1:0] dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    output logic [CW-1:0]        x_next,
    output logic [CW-1:0]        y_next,
    output logic signed [CW+1:0] err_next,
    output logic                 at_target
);
    import enemy_pkg::*;

    localparam logic [CW-1:0] ONE = CW'(1);

    logic signed [CW+2:0] e2;
    logic signed [CW+2:0] dx_w;
    logic signed [CW+2:0] dy_w;

    // Both axis decisions use the error value from before this step.
    always_comb begin
        e2       = {err[CW+1], err} <<< 1;
        dx_w     = {dx[CW+1], dx};
        dy_w     = {dy[CW+1], dy};
        x_next   = x;
        y_next   = y;
        err_next = err;
        if (e2 > -dy_w) begin
            err_next = err_next - dy;
            x_next   = sx_neg ? (x - ONE) : (x + ONE);
        end
        if (e2 < dx_w) begin
            err_next = err_next + dx;
            y_next   = sy_neg ? (y - ONE) : (y + ONE);
        end
        at_target = (x_next == CW'(TX)) && (y_next == CW'(TY));
    end

endmodule

// File: rtl/enemy_mover.sv
// Per-enemy motion engine: latches a spawn point, then walks a Bresenham
// line toward the player, taking up to 'speed' steps after each frame tick.
module enemy_mover #(
    parameter int TARGET_X = enemy_pkg::TARGET_X,
    parameter int TARGET_Y = enemy_pkg::TARGET_Y,
    parameter int CW       = enemy_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spawn_req,
    input  logic [CW-1:0] spawn_x,
    input  logic [CW-1:0] spawn_y,
    input  logic [1:0]    speed,
    input  logic          frame_tick,
    input  logic          kill,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          active,
    output logic          reached,
    output logic          killed
);
    import enemy_pkg::*;

    state_t               state_reg, state_next;
    logic [CW-1:0]        pos_x_reg, pos_x_next;
    logic [CW-1:0]        pos_y_reg, pos_y_next;
    logic signed [CW+1:0] err_reg, err_next;
    logic signed [CW+1:0] dx_reg, dx_next;
    logic signed [CW+1:0] dy_reg, dy_next;
    logic                 sx_reg, sx_next;
    logic                 sy_reg, sy_next;
    logic [1:0]           spd_reg, spd_next;
    logic [1:0]           steps_reg, steps_next;
    logic                 reached_reg, reached_next;
    logic                 killed_reg, killed_next;

    logic signed [CW+1:0] diff_x, diff_y;
    logic [CW-1:0]        step_x, step_y;
    logic signed [CW+1:0] step_err;
    logic                 step_hit;

    // Signed offset from the current position to the target on each axis.
    assign diff_x = $signed({2'b00, CW'(TARGET_X)}) - $signed({2'b00, pos_x_reg});
    assign diff_y = $signed({2'b00, CW'(TARGET_Y)}) - $signed({2'b00, pos_y_reg});

    line_stepper #(
        .CW (CW),
        .TX (TARGET_X),
        .TY (TARGET_Y)
    ) u_stepper (
        .x         (pos_x_reg),
        .y         (pos_y_reg),
        .err       (err_reg),
        .dx        (dx_reg),
        .dy        (dy_reg),
        .sx_neg    (sx_reg),
        .sy_neg    (sy_reg),
        .x_next    (step_x),
        .y_next    (step_y),
        .err_next  (step_err),
        .at_target (step_hit)
    );

    // State and datapath registers; async reset clears all visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pos_x_reg   <= '0;
            pos_y_reg   <= '0;
            err_reg     <= '0;
            dx_reg      <= '0;
            dy_reg      <= '0;
            sx_reg      <= 1'b0;
            sy_reg      <= 1'b0;
            spd_reg     <= 2'd1;
            steps_reg   <= 2'd0;
            reached_reg <= 1'b0;
            killed_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pos_x_reg   <= pos_x_next;
            pos_y_reg   <= pos_y_next;
            err_reg     <= err_next;
            dx_reg      <= dx_next;
            dy_reg      <= dy_next;
            sx_reg      <= sx_next;
            sy_reg      <= sy_next;
            spd_reg     <= spd_next;
            steps_reg   <= steps_next;
            reached_reg <= reached_next;
            killed_reg  <= killed_next;
        end
    end

    // Next-state logic; kill takes priority over any movement or arrival.
    always_comb begin
        state_next   = state_reg;
        pos_x_next   = pos_x_reg;
        pos_y_next   = pos_y_reg;
        err_next     = err_reg;
        dx_next      = dx_reg;
        dy_next      = dy_reg;
        sx_next      = sx_reg;
        sy_next      = sy_reg;
        spd_next     = spd_reg;
        steps_next   = steps_reg;
        reached_next = 1'b0;
        killed_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (spawn_req) begin
                    pos_x_next = spawn_x;
                    pos_y_next = spawn_y;
                    spd_next   = (speed == 2'd0) ? 2'd1 : speed;
                    state_next = INIT;
                end
            end
            INIT: begin
                if (kill) begin
                    killed_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    sx_next    = diff_x[CW+1];
                    sy_next    = diff_y[CW+1];
                    dx_next    = diff_x[CW+1] ? -diff_x : diff_x;
                    dy_next    = diff_y[CW+1] ? -diff_y : diff_y;
                    err_next   = (diff_x[CW+1] ? -diff_x : diff_x)
                               - (diff_y[CW+1] ? -diff_y : diff_y);
                    steps_next = spd_reg;
                    if ((diff_x == '0) && (diff_y == '0)) begin
                        reached_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (kill) begin
                    killed_next = 1'b1;
                    state_next  = IDLE;
                end else if (frame_tick) begin
                    steps_next = spd_reg;
                    state_next = STEP;
                end
            end
            STEP: begin
                if (kill) begin
                    killed_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    pos_x_next = step_x;
                    pos_y_next = step_y;
                    err_next   = step_err;
                    steps_next = steps_reg - 2'd1;
                    if (step_hit) begin
                        reached_next = 1'b1;
                        state_next   = IDLE;
                    end else if (steps_reg == 2'd1) begin
                        state_next = WAIT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pos_x   = pos_x_reg;
    assign pos_y   = pos_y_reg;
    assign active  = (state_reg != IDLE);
    assign reached = reached_reg;
    assign killed  = killed_reg;

endmodule
